ocp_arb2: RTL and testbench
===========================

OCP_ARB2 -- requirements
Module: ocp_arb2

Interface
REQ-001 Parameter: TIMEOUT, default 16, response-wait limit in cycles (legal 2..255).
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Ports (master 0 side): i_M0Addr in ADDR_WIDTH; i_M0Cmd in 3; i_M0Data in DATA_WIDTH; i_M0ByteEn in BEN_WIDTH; o_S0CmdAccept out 1; o_S0Data out DATA_WIDTH; o_S0Resp out 2.
REQ-005 Ports (master 1 side): i_M1Addr, i_M1Cmd, i_M1Data, i_M1ByteEn, o_S1CmdAccept, o_S1Data, o_S1Resp; widths identical to REQ-004.
REQ-006 Ports (slave side, to memory): o_MAddr out ADDR_WIDTH; o_MCmd out 3; o_MData out DATA_WIDTH; o_MByteEn out BEN_WIDTH; i_SCmdAccept in 1; i_SData in DATA_WIDTH; i_SResp in 2.
REQ-007 Encodings: CMD IDLE=0, WRITE=1, READ=2; RESP NULL=0, DVA=1, FAIL=2, ERR=3; other MCmd values treated as IDLE.

Function
REQ-008 Block shall share one OCP slave between two masters, one outstanding transaction at a time.
REQ-009 States: IDLE, WAIT_RESP; registered owner bit (own), priority bit (pri), wait counter (cnt, 8 bits).
REQ-010 IDLE: requesting master = any master with Cmd WRITE/READ; if both request, grant master pri; if one, grant it.
REQ-011 IDLE with grant: o_MAddr/o_MCmd/o_MData/o_MByteEn combinationally equal granted master's inputs; o_SxCmdAccept of granted master = i_SCmdAccept; other master's accept = 0.
REQ-012 IDLE without request: o_MCmd=IDLE, o_MAddr/o_MData/o_MByteEn=0, both accepts 0.
REQ-013 IDLE -> WAIT_RESP when granted command and i_SCmdAccept=1 in same cycle; own <= granted index, cnt <= 0.
REQ-014 If i_SCmdAccept=0, stay IDLE; grant re-evaluated next cycle (master must hold command per OCP).
REQ-015 WAIT_RESP: o_MCmd=IDLE, both accepts 0; new requests stall.
REQ-016 WAIT_RESP with i_SResp != NULL: o_S<own>Resp=i_SResp, o_S<own>Data=i_SData combinationally; -> IDLE; pri <= ~own.
REQ-017 WAIT_RESP with i_SResp=NULL: cnt <= cnt+1; when cnt==TIMEOUT-1 same cycle: o_S<own>Resp=ERR, o_S<own>Data=0, -> IDLE, pri <= ~own.
REQ-018 Non-owner master: Resp=NULL, Data=0 at all times; in IDLE both masters see Resp=NULL, Data=0.
REQ-019 Any i_SResp != NULL arriving in IDLE (late response after timeout) shall be discarded.
REQ-020 Minimum transaction spacing: 2 cycles (command cycle, response cycle) for a slave responding 1 cycle after accept.
REQ-021 Round-robin: under continuous requests from both masters, grants alternate strictly 0,1,0,1...

Reset
REQ-022 rst=1 at rising edge: state <= IDLE, own <= 0, pri <= 0 (master 0 first), cnt <= 0.
REQ-023 While rst=1: o_MCmd=IDLE, o_MAddr/o_MData/o_MByteEn=0, both accepts 0, both Resp=NULL, both Data=0, regardless of inputs.
REQ-024 Reset mid-transaction abandons it; no response delivered; slave response arriving the cycle after reset release is discarded per REQ-019.

Verification
REQ-025 Single read: M0 READ addr 0x10, slave accepts, next cycle SResp=DVA SData=0xCAFEF00D -> o_S0CmdAccept=1 in cycle 0, o_S0Resp=DVA, o_S0Data=0xCAFEF00D in cycle 1, M1 sees NULL.
REQ-026 Contention: both masters WRITE from reset, slave always accepts, DVA next cycle -> M0 granted cycle 0, M1 granted cycle 2, M0 again cycle 4; o_MData tracks granted master.
REQ-027 Backpressure: M1 READ, i_SCmdAccept=0 for 3 cycles then 1 -> o_S1CmdAccept low 3 cycles, high cycle 3; o_MCmd=READ cycles 0-3; WAIT_RESP from cycle 4.
REQ-028 Timeout: TIMEOUT=4, M0 READ accepted, slave never responds -> o_S0Resp=ERR, o_S0Data=0 exactly 4 cycles after accept cycle; late DVA afterward not forwarded to either master.
REQ-029 Reset mid-operation: rst=1 during WAIT_RESP with slave DVA same cycle -> no Resp to either master; after release M1 request granted only if M0 idle (pri=0).
REQ-030 Invalid command: M0 Cmd=3'b111, M1 idle -> o_MCmd=IDLE, no accept, state stays IDLE.

Source files
------------

// File: rtl/ocp_arb2_if.sv
// One OCP point-to-point link. The "master" side issues commands and
// receives responses; the "slave" side accepts commands and returns data.
interface ocp_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4
);
    logic [ADDR_WIDTH-1:0] maddr;
    logic [2:0]            mcmd;
    logic [DATA_WIDTH-1:0] mdata;
    logic [BEN_WIDTH-1:0]  mbyteen;
    logic                  scmdaccept;
    logic [DATA_WIDTH-1:0] sdata;
    logic [1:0]            sresp;

    modport master (
        output maddr, mcmd, mdata, mbyteen,
        input  scmdaccept, sdata, sresp
    );

    modport slave (
        input  maddr, mcmd, mdata, mbyteen,
        output scmdaccept, sdata, sresp
    );
endinterface

// File: rtl/ocp_arb2.sv
// Two-master OCP arbiter sharing one slave, one outstanding transaction at a
// time, round-robin grant and a response-wait timeout that returns ERR.
module ocp_arb2 #(
    parameter int TIMEOUT    = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4
) (
    input  logic   clk,
    input  logic   rst,
    ocp_if.slave   m0,
    ocp_if.slave   m1,
    ocp_if.master  mem
);
    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_READ  = 3'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0] state;
    logic       own;
    logic       pri;
    logic [7:0] cnt;

    logic req0, req1, any_req, gnt;
    logic resp_hit, tmo_hit, done;

    assign req0    = (m0.mcmd == CMD_WRITE) || (m0.mcmd == CMD_READ);
    assign req1    = (m1.mcmd == CMD_WRITE) || (m1.mcmd == CMD_READ);
    assign any_req = req0 || req1;
    assign gnt     = (req0 && req1) ? pri : req1;

    assign resp_hit = (state == S_WAIT) && (mem.sresp != RESP_NULL);
    assign tmo_hit  = (state == S_WAIT) && (mem.sresp == RESP_NULL) && (cnt == CNT_LAST);
    assign done     = resp_hit || tmo_hit;

    always_comb begin
        mem.maddr     = '0;
        mem.mcmd      = CMD_IDLE;
        mem.mdata     = '0;
        mem.mbyteen   = '0;
        m0.scmdaccept = 1'b0;
        m1.scmdaccept = 1'b0;
        m0.sresp      = RESP_NULL;
        m0.sdata      = '0;
        m1.sresp      = RESP_NULL;
        m1.sdata      = '0;
        if (!rst) begin
            if (state == S_IDLE) begin
                if (any_req) begin
                    if (gnt) begin
                        mem.maddr     = m1.maddr;
                        mem.mcmd      = m1.mcmd;
                        mem.mdata     = m1.mdata;
                        mem.mbyteen   = m1.mbyteen;
                        m1.scmdaccept = mem.scmdaccept;
                    end else begin
                        mem.maddr     = m0.maddr;
                        mem.mcmd      = m0.mcmd;
                        mem.mdata     = m0.mdata;
                        mem.mbyteen   = m0.mbyteen;
                        m0.scmdaccept = mem.scmdaccept;
                    end
                end
            end else if (done) begin
                // A timeout reports ERR with zero data; a real response is passed through.
                if (own) begin
                    m1.sresp = resp_hit ? mem.sresp : RESP_ERR;
                    m1.sdata = resp_hit ? mem.sdata : '0;
                end else begin
                    m0.sresp = resp_hit ? mem.sresp : RESP_ERR;
                    m0.sdata = resp_hit ? mem.sdata : '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            own   <= 1'b0;
            pri   <= 1'b0;
            cnt   <= '0;
        end else if (state == S_IDLE) begin
            if (any_req && mem.scmdaccept) begin
                state <= S_WAIT;
                own   <= gnt;
                cnt   <= '0;
            end
        end else if (done) begin
            state <= S_IDLE;
            pri   <= ~own;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_ocp_arb2.sv
// Scoreboard bench: stimulus queues the expected visible event for each
// cycle where something should happen; the monitor compares every event seen.
module tb_ocp_arb2;
    localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, RD = 3'd2;
    localparam logic [1:0] NUL = 2'd0, DVA = 2'd1, ERR = 2'd3;

    typedef struct packed {
        logic        acc0;
        logic        acc1;
        logic [2:0]  mcmd;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [3:0]  mben;
        logic [1:0]  r0;
        logic [31:0] d0;
        logic [1:0]  r1;
        logic [31:0] d1;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    ev_t  q[$];

    always #5 clk = ~clk;

    ocp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BEN_WIDTH(4)) m0_bus ();
    ocp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BEN_WIDTH(4)) m1_bus ();
    ocp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BEN_WIDTH(4)) mem_bus ();

    ocp_arb2 #(.TIMEOUT(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BEN_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .mem (mem_bus)
    );

    function automatic ev_t e_cmd(input logic a0, input logic a1, input logic [2:0] c,
                                  input logic [31:0] a, input logic [31:0] d);
        ev_t e = '0;
        e.acc0 = a0; e.acc1 = a1; e.mcmd = c; e.maddr = a; e.mdata = d; e.mben = 4'hf;
        return e;
    endfunction

    function automatic ev_t e_rsp(input logic [1:0] r0, input logic [31:0] d0,
                                  input logic [1:0] r1, input logic [31:0] d1);
        ev_t e = '0;
        e.r0 = r0; e.d0 = d0; e.r1 = r1; e.d1 = d1;
        return e;
    endfunction

    task automatic drv_m(input int m, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_bus.mcmd = c; m0_bus.maddr = a; m0_bus.mdata = d; m0_bus.mbyteen = 4'hf;
        end else begin
            m1_bus.mcmd = c; m1_bus.maddr = a; m1_bus.mdata = d; m1_bus.mbyteen = 4'hf;
        end
    endtask

    task automatic drv_s(input logic acc, input logic [1:0] r, input logic [31:0] d);
        mem_bus.scmdaccept = acc; mem_bus.sresp = r; mem_bus.sdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with an accept, a response or a command on the slave side is an event.
    always @(negedge clk) begin
        ev_t got;
        ev_t exp_e;
        got.acc0  = m0_bus.scmdaccept;
        got.acc1  = m1_bus.scmdaccept;
        got.mcmd  = mem_bus.mcmd;
        got.maddr = mem_bus.maddr;
        got.mdata = mem_bus.mdata;
        got.mben  = mem_bus.mbyteen;
        got.r0    = m0_bus.sresp;
        got.d0    = m0_bus.sdata;
        got.r1    = m1_bus.sresp;
        got.d1    = m1_bus.sdata;
        if (got.acc0 || got.acc1 || got.r0 != NUL || got.r1 != NUL || got.mcmd != IDLE) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event t=%0t got=%h required=none", $time, got);
            end else begin
                exp_e = q.pop_front();
                if (got !== exp_e) begin
                    fails++;
                    $display("FAIL event t=%0t got=%h required=%h", $time, got, exp_e);
                end
            end
        end
    end

    initial begin
        // Reset with every input active: nothing may leak to any port.
        drv_m(0, RD, 32'h1, 32'h2); drv_m(1, WR, 32'h3, 32'h4); drv_s(1'b1, DVA, 32'h5);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        drv_m(0, IDLE, 0, 0); drv_m(1, IDLE, 0, 0); drv_s(1'b0, NUL, 0);
        step();

        // Single read from M0.
        drv_m(0, RD, 32'h10, 0); drv_s(1'b1, NUL, 0);
        q.push_back(e_cmd(1, 0, RD, 32'h10, 0));
        step();
        drv_m(0, IDLE, 0, 0); drv_s(1'b1, DVA, 32'hCAFEF00D);
        q.push_back(e_rsp(DVA, 32'hCAFEF00D, NUL, 0));
        step();
        drv_s(1'b0, NUL, 0);
        rst = 1'b1; step(); rst = 1'b0;

        // Contention from reset: grants alternate 0,1,0.
        drv_m(0, WR, 32'h100, 32'hA0A0A0A0); drv_m(1, WR, 32'h200, 32'hB1B1B1B1);
        drv_s(1'b1, NUL, 0);
        q.push_back(e_cmd(1, 0, WR, 32'h100, 32'hA0A0A0A0));
        step();
        drv_s(1'b1, DVA, 32'h11111111);
        q.push_back(e_rsp(DVA, 32'h11111111, NUL, 0));
        step();
        drv_s(1'b1, NUL, 0);
        q.push_back(e_cmd(0, 1, WR, 32'h200, 32'hB1B1B1B1));
        step();
        drv_s(1'b1, DVA, 32'h22222222);
        q.push_back(e_rsp(NUL, 0, DVA, 32'h22222222));
        step();
        drv_s(1'b1, NUL, 0);
        q.push_back(e_cmd(1, 0, WR, 32'h100, 32'hA0A0A0A0));
        step();
        drv_m(0, IDLE, 0, 0); drv_m(1, IDLE, 0, 0); drv_s(1'b1, DVA, 32'h33333333);
        q.push_back(e_rsp(DVA, 32'h33333333, NUL, 0));
        step();

        // Backpressure on M1: three refused cycles, accepted on the fourth.
        drv_m(1, RD, 32'h20, 0); drv_s(1'b0, NUL, 0);
        for (int i = 0; i < 3; i++) begin
            q.push_back(e_cmd(0, 0, RD, 32'h20, 0));
            step();
        end
        drv_s(1'b1, NUL, 0);
        q.push_back(e_cmd(0, 1, RD, 32'h20, 0));
        step();
        drv_m(1, IDLE, 0, 0); drv_s(1'b0, NUL, 0);
        step();
        drv_s(1'b0, DVA, 32'h55555555);
        q.push_back(e_rsp(NUL, 0, DVA, 32'h55555555));
        step();

        // Timeout: ERR four cycles after accept, late DVA dropped.
        drv_m(0, RD, 32'h30, 0); drv_s(1'b1, NUL, 0);
        q.push_back(e_cmd(1, 0, RD, 32'h30, 0));
        step();
        drv_m(0, IDLE, 0, 0); drv_s(1'b1, NUL, 32'hDEADDEAD);
        step(); step(); step();
        q.push_back(e_rsp(ERR, 0, NUL, 0));
        step();
        drv_s(1'b1, DVA, 32'h0000BEEF);
        step();
        drv_s(1'b0, NUL, 0);
        step();

        // Reset during WAIT_RESP with a same-cycle DVA, then priority back to M0.
        drv_m(1, RD, 32'h60, 0); drv_s(1'b1, NUL, 0);
        q.push_back(e_cmd(0, 1, RD, 32'h60, 0));
        step();
        drv_m(1, IDLE, 0, 0); drv_s(1'b0, DVA, 32'h66666666);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drv_m(0, RD, 32'h40, 0); drv_m(1, RD, 32'h50, 0); drv_s(1'b0, DVA, 32'h67676767);
        q.push_back(e_cmd(0, 0, RD, 32'h40, 0));
        step();
        drv_s(1'b1, NUL, 0);
        q.push_back(e_cmd(1, 0, RD, 32'h40, 0));
        step();
        drv_m(0, IDLE, 0, 0); drv_s(1'b1, DVA, 32'h77777777);
        q.push_back(e_rsp(DVA, 32'h77777777, NUL, 0));
        step();
        drv_s(1'b1, NUL, 0);
        q.push_back(e_cmd(0, 1, RD, 32'h50, 0));
        step();
        drv_m(1, IDLE, 0, 0); drv_s(1'b1, DVA, 32'h88888888);
        q.push_back(e_rsp(NUL, 0, DVA, 32'h88888888));
        step();

        // Invalid command is ignored; arbiter remains free for M1.
        drv_m(0, 3'b111, 32'h70, 32'h71); drv_s(1'b1, NUL, 0);
        step(); step(); step();
        drv_m(1, RD, 32'h90, 0);
        q.push_back(e_cmd(0, 1, RD, 32'h90, 0));
        step();
        drv_m(0, IDLE, 0, 0); drv_m(1, IDLE, 0, 0); drv_s(1'b1, DVA, 32'h99999999);
        q.push_back(e_rsp(NUL, 0, DVA, 32'h99999999));
        step();
        drv_s(1'b0, NUL, 0);
        step(); step();

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_events got=%0d pending required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
